// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, DEPTH-entry {instr, pc, err} buffer,
// flush/refetch on redirect, fetch stop on halt sentinel or access error. Optional macro IFQ_BYPASS_EN.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        deq_ready,
  output logic        deq_valid,
  output logic [31:0] deq_instr,
  output logic [63:0] deq_pc,
  output logic        deq_err,
  output logic        halted
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic [63:0]      r_fetch_pc;
  logic [CW-1:0]    r_count, r_outstanding, r_discard;
  logic [PW-1:0]    r_rd_ptr, r_wr_ptr, r_tag_rd, r_tag_wr;
  logic [31:0]      r_q_instr [DEPTH];
  logic [63:0]      r_q_pc    [DEPTH];
  logic [DEPTH-1:0] r_q_err;
  logic [63:0]      r_tag_pc  [DEPTH];

  logic [CW:0]   w_inuse;
  logic [CW-1:0] w_out_after_rsp;
  logic [63:0]   w_rsp_pc;
  logic          w_req_valid, w_req_fire, w_rsp_keep, w_stop;
  logic          w_bypass, w_head_valid, w_enq, w_deq;

  // Credits: queued entries plus in-flight requests never exceed DEPTH, so the buffer cannot overflow.
  assign w_inuse         = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid     = !reset && (r_state == RUN) && !redirect_valid && (w_inuse < (CW+1)'(DEPTH));
  assign w_req_fire      = w_req_valid && imem_req_ready;
  assign w_rsp_keep      = imem_rsp_valid && !redirect_valid && (r_discard == '0);
  assign w_rsp_pc        = r_tag_pc[r_tag_rd];
  assign w_stop          = w_rsp_keep && ((imem_rsp_data == 32'hFFFF_FFFF) || imem_rsp_err);
  assign w_out_after_rsp = r_outstanding - CW'(imem_rsp_valid);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign deq_valid      = !reset && w_head_valid;
  assign halted         = !reset && (r_state == HALT);

`ifdef IFQ_BYPASS_EN
  assign w_bypass     = w_rsp_keep && (r_count == '0);
  assign w_head_valid = (r_count != '0) || w_bypass;
  assign deq_instr    = !deq_valid ? '0 : (w_bypass ? imem_rsp_data : r_q_instr[r_rd_ptr]);
  assign deq_pc       = !deq_valid ? '0 : (w_bypass ? w_rsp_pc : r_q_pc[r_rd_ptr]);
  assign deq_err      = deq_valid && (w_bypass ? imem_rsp_err : r_q_err[r_rd_ptr]);
`else
  assign w_bypass     = 1'b0;
  assign w_head_valid = (r_count != '0);
  assign deq_instr    = deq_valid ? r_q_instr[r_rd_ptr] : '0;
  assign deq_pc       = deq_valid ? r_q_pc[r_rd_ptr] : '0;
  assign deq_err      = deq_valid && r_q_err[r_rd_ptr];
`endif

  // A bypassed response that is consumed immediately is never written.
  assign w_enq = w_rsp_keep && !(w_bypass && deq_ready);
  assign w_deq = (r_count != '0) && deq_ready && !redirect_valid;

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = RUN;
    end else if (w_stop) begin
      w_state_nxt = HALT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
    end else begin
      r_state <= w_state_nxt;
      // The PC tag FIFO tracks every request, including ones whose responses get discarded.
      if (w_req_fire)     r_tag_wr <= r_tag_wr + PW'(1);
      if (imem_rsp_valid) r_tag_rd <= r_tag_rd + PW'(1);
      if (redirect_valid) begin
        r_fetch_pc    <= redirect_pc & ~64'h3;
        r_count       <= '0;
        r_rd_ptr      <= '0;
        r_wr_ptr      <= '0;
        r_outstanding <= w_out_after_rsp;
        r_discard     <= w_out_after_rsp;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 64'd4;
        r_outstanding <= w_out_after_rsp + CW'(w_req_fire);
        if (imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
        if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_req_fire) r_tag_pc[r_tag_wr] <= r_fetch_pc;
    if (w_enq) begin
      r_q_instr[r_wr_ptr] <= imem_rsp_data;
      r_q_pc[r_wr_ptr]    <= w_rsp_pc;
      r_q_err[r_wr_ptr]   <= imem_rsp_err;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: cycle vector table, directed redirect/halt/error/reset sequences,
// and a randomized run against a queue-based reference model with an in-order memory model.
module tb_inst_prefetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [63:0] deq_pc;
  logic        deq_err;
  logic        halted;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc),
    .deq_err(deq_err), .halted(halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  bit rand_mode = 1'b0;
  bit rand_faults = 1'b0;
  logic [63:0] sent_addr = 64'h1;
  logic [63:0] err_addr  = 64'h1;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc; logic err; } ent_t;
  mreq_t mq[$];
  infl_t m_infl[$];
  ent_t  m_q[$];
  logic [63:0] m_fpc = RESET_PC;
  bit m_halt = 1'b0;
  bit m_erv, m_edv;

  logic s_rv, s_dv, s_err, s_halt;
  logic [63:0] s_ra, s_pc;
  logic [31:0] s_instr;

  typedef struct { bit rst; bit dr; bit erv; logic [63:0] era; bit edv; logic [63:0] epc; } vec_t;
  localparam int NV = 22;
  vec_t tbl[NV];

  function automatic vec_t mk(input bit r, input bit d, input bit rv, input logic [63:0] ra,
                              input bit dv, input logic [63:0] pc);
    vec_t v;
    v.rst = r; v.dr = d; v.erv = rv; v.era = ra; v.edv = dv; v.epc = pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    if (a == sent_addr || (rand_faults && (a[11:2] % 10'd37) == 10'd5)) return 32'hFFFF_FFFF;
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  function automatic logic mem_err(input logic [63:0] a);
    return (a == err_addr) || (rand_faults && (a[11:2] % 10'd41) == 10'd7);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_check();
    m_erv = !reset && !m_halt && !redirect_valid && ((m_q.size() + m_infl.size()) < int'(DEPTH));
    m_edv = !reset && (m_q.size() > 0);
    chk("mdl_req_valid", 64'(s_rv), 64'(m_erv));
    if (!reset) chk("mdl_req_addr", s_ra, m_fpc);
    chk("mdl_deq_valid", 64'(s_dv), 64'(m_edv));
    chk("mdl_halted", 64'(s_halt), 64'(!reset && m_halt));
    if (m_edv) begin
      chk("mdl_deq_pc", s_pc, m_q[0].pc);
      chk("mdl_deq_instr", 64'(s_instr), 64'(m_q[0].instr));
      chk("mdl_deq_err", 64'(s_err), 64'(m_q[0].err));
    end
  endtask

  task automatic model_update();
    infl_t it;
    if (reset) begin
      m_q.delete(); m_infl.delete(); m_fpc = RESET_PC; m_halt = 1'b0;
    end else if (redirect_valid) begin
      if (imem_rsp_valid && m_infl.size() > 0) m_infl.delete(0);
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_q.delete();
      m_fpc = redirect_pc & ~64'h3;
      m_halt = 1'b0;
    end else begin
      if (m_edv && deq_ready) m_q.delete(0);
      if (imem_rsp_valid && m_infl.size() > 0) begin
        it = m_infl[0];
        m_infl.delete(0);
        if (!it.stale) begin
          m_q.push_back('{imem_rsp_data, it.pc, imem_rsp_err});
          if (imem_rsp_data == 32'hFFFF_FFFF || imem_rsp_err) m_halt = 1'b1;
        end
      end
      if (m_erv && imem_req_ready) begin
        m_infl.push_back('{m_fpc, 1'b0});
        m_fpc = m_fpc + 64'd4;
      end
    end
  endtask

  // One clock cycle: drive memory, sample at negedge, check and advance the model, advance memory.
  task automatic step();
    bit acc, rsp;
    logic [63:0] acc_addr;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc && (!rand_mode || $urandom_range(0, 2) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mq[0].addr);
      imem_rsp_err   = mem_err(mq[0].addr);
    end
    imem_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(negedge clock);
    s_rv = imem_req_valid; s_ra = imem_req_addr; s_dv = deq_valid; s_pc = deq_pc;
    s_instr = deq_instr; s_err = deq_err; s_halt = halted;
    model_check();
    acc = imem_req_valid && imem_req_ready && !reset;
    acc_addr = imem_req_addr;
    rsp = imem_rsp_valid;
    model_update();
    @(posedge clock); #1;
    if (reset) mq.delete();
    else begin
      if (rsp && mq.size() > 0) mq.delete(0);
      if (acc) mq.push_back('{acc_addr, cyc + lat});
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  int n_deq, seen_halt, req_after_halt;
  logic [63:0] dpc [3];
  logic [31:0] dins [3];

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;

    // Streaming from reset with 1-cycle memory, then a 10-cycle stall from reset.
    tbl[0]  = mk(1, 1, 1, 64'h0,  0, 64'h0);
    tbl[1]  = mk(0, 1, 1, 64'h4,  0, 64'h0);
    tbl[2]  = mk(0, 1, 1, 64'h8,  1, 64'h0);
    tbl[3]  = mk(0, 1, 1, 64'hC,  1, 64'h4);
    tbl[4]  = mk(0, 1, 1, 64'h10, 1, 64'h8);
    tbl[5]  = mk(0, 1, 1, 64'h14, 1, 64'hC);
    tbl[6]  = mk(1, 0, 1, 64'h0,  0, 64'h0);
    tbl[7]  = mk(0, 0, 1, 64'h4,  0, 64'h0);
    tbl[8]  = mk(0, 0, 1, 64'h8,  1, 64'h0);
    tbl[9]  = mk(0, 0, 1, 64'hC,  1, 64'h0);
    for (int i = 10; i <= 16; i++) tbl[i] = mk(0, 0, 0, 64'h10, 1, 64'h0);
    tbl[16].dr = 1'b1;
    tbl[17] = mk(0, 1, 1, 64'h10, 1, 64'h4);
    tbl[18] = mk(0, 1, 1, 64'h14, 1, 64'h8);
    tbl[19] = mk(0, 1, 1, 64'h18, 1, 64'hC);
    tbl[20] = mk(0, 1, 1, 64'h1C, 1, 64'h10);
    tbl[21] = mk(0, 1, 1, 64'h20, 1, 64'h14);

    @(posedge clock); #1;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst) do_reset();
      deq_ready = tbl[i].dr;
      step();
      chk($sformatf("vec%0d_req_valid", i), 64'(s_rv), 64'(tbl[i].erv));
      chk($sformatf("vec%0d_req_addr", i), s_ra, tbl[i].era);
      chk($sformatf("vec%0d_deq_valid", i), 64'(s_dv), 64'(tbl[i].edv));
      if (tbl[i].edv) begin
        chk($sformatf("vec%0d_deq_pc", i), s_pc, tbl[i].epc);
        chk($sformatf("vec%0d_deq_instr", i), 64'(s_instr), 64'(mem_data(tbl[i].epc)));
      end
    end

    // Redirect to 0x40 with two requests in flight, 3-cycle memory.
    lat = 3; deq_ready = 1'b1; do_reset();
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 64'h40; step(); redirect_valid = 1'b0;
    chk("redir_cycle_no_req", 64'(s_rv), 64'd0);
    step();
    chk("redir_next_req_valid", 64'(s_rv), 64'd1);
    chk("redir_next_req_addr", s_ra, 64'h40);
    chk("redir_next_deq_valid", 64'(s_dv), 64'd0);
    for (int k = 0; k < 20 && !s_dv; k++) step();
    chk("redir_first_valid", 64'(s_dv), 64'd1);
    chk("redir_first_pc", s_pc, 64'h40);
    step();
    chk("redir_second_valid", 64'(s_dv), 64'd1);
    chk("redir_second_pc", s_pc, 64'h44);

    // Halt sentinel at 0x8.
    lat = 1; sent_addr = 64'h8; deq_ready = 1'b1; do_reset();
    n_deq = 0; seen_halt = 0; req_after_halt = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (s_halt) seen_halt = 1;
      if (s_halt && s_rv) req_after_halt++;
      if (s_dv) begin
        if (n_deq < 3) begin dpc[n_deq] = s_pc; dins[n_deq] = s_instr; end
        n_deq++;
      end
    end
    chk("halt_seen", 64'(seen_halt), 64'd1);
    chk("halt_no_req", 64'(req_after_halt), 64'd0);
    chk("halt_deq_at_least_3", 64'(n_deq >= 3), 64'd1);
    chk("halt_pc0", dpc[0], 64'h0);
    chk("halt_pc1", dpc[1], 64'h4);
    chk("halt_pc2", dpc[2], 64'h8);
    chk("halt_sentinel_instr", 64'(dins[2]), 64'hFFFF_FFFF);
    sent_addr = 64'h1;
    redirect_valid = 1'b1; redirect_pc = 64'h0; step(); redirect_valid = 1'b0;
    step();
    chk("resume_halted", 64'(s_halt), 64'd0);
    chk("resume_req_valid", 64'(s_rv), 64'd1);
    chk("resume_req_addr", s_ra, 64'h0);

    // Access error at 0x1000.
    err_addr = 64'h1000;
    redirect_valid = 1'b1; redirect_pc = 64'h1000; step(); redirect_valid = 1'b0;
    for (int k = 0; k < 20 && !(s_dv && s_pc == 64'h1000); k++) step();
    chk("err_entry_pc", s_pc, 64'h1000);
    chk("err_entry_valid", 64'(s_dv), 64'd1);
    chk("err_flag", 64'(s_err), 64'd1);
    chk("err_halted", 64'(s_halt), 64'd1);
    err_addr = 64'h1;

    // Reset in the middle of traffic with requests outstanding.
    lat = 3; deq_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h200; step(); redirect_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    reset = 1'b1; step();
    chk("midrst_req_valid", 64'(s_rv), 64'd0);
    chk("midrst_deq_valid", 64'(s_dv), 64'd0);
    reset = 1'b0; step();
    chk("postrst_req_valid", 64'(s_rv), 64'd1);
    chk("postrst_req_addr", s_ra, RESET_PC);
    chk("postrst_deq_valid", 64'(s_dv), 64'd0);
    chk("postrst_halted", 64'(s_halt), 64'd0);
    deq_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();

    // Randomized traffic against the reference model.
    rand_mode = 1'b1; rand_faults = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) lat = int'($urandom_range(1, 4));
      reset = ($urandom_range(0, 399) == 0);
      deq_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = !reset && ($urandom_range(0, 17) == 0);
      redirect_pc = {$urandom, $urandom};
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
